// File: rtl/pattern_sequencer.sv
// pattern_sequencer: per-channel responder for the note-pattern handshake.
// Each i_enable strobe fetches the next entry from a synchronous pattern ROM,
// decodes {END, REST, pitch, duration} and returns it with a one-cycle o_valid.
// Build option: define PATTERN_SEQUENCER_LOOP_EN to make END entries jump to
// i_loop_addr; without it an END entry halts the sequencer.
module pattern_sequencer #(
  parameter int ADDR_WIDTH     = 6,
  parameter int PITCH_WIDTH    = 6,
  parameter int DURATION_WIDTH = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_enable,
  input  logic                                  i_restart,
  input  logic [ADDR_WIDTH-1:0]                 i_start_addr,
  input  logic [ADDR_WIDTH-1:0]                 i_loop_addr,
  output logic                                  o_valid,
  output logic [PITCH_WIDTH-1:0]                o_pitch,
  output logic [DURATION_WIDTH-1:0]             o_duration,
  output logic                                  o_rest,
  output logic                                  o_halted,
  output logic                                  o_busy,
  output logic                                  o_rom_en,
  output logic [ADDR_WIDTH-1:0]                 o_rom_addr,
  input  logic [2+PITCH_WIDTH+DURATION_WIDTH-1:0] i_rom_data
);

  localparam int ENTRY_WIDTH = 2 + PITCH_WIDTH + DURATION_WIDTH;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] FETCH      = 2'd1;
  localparam logic [1:0] WAIT       = 2'd2;
  localparam logic [1:0] DECODE_END = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;

  // Field split of the ROM word, MSB first: END, REST, pitch, duration.
  logic                      entry_end;
  logic                      entry_rest;
  logic [PITCH_WIDTH-1:0]    entry_pitch;
  logic [DURATION_WIDTH-1:0] entry_duration;

  assign entry_end      = i_rom_data[ENTRY_WIDTH-1];
  assign entry_rest     = i_rom_data[ENTRY_WIDTH-2];
  assign entry_pitch    = i_rom_data[DURATION_WIDTH +: PITCH_WIDTH];
  assign entry_duration = i_rom_data[DURATION_WIDTH-1:0];

  // ROM port and busy flag are decoded straight from state/pointer so the
  // read is issued in the FETCH cycle itself.
  assign o_rom_en   = (state == FETCH);
  assign o_rom_addr = ptr;
  assign o_busy     = (state != IDLE);

`ifdef PATTERN_SEQUENCER_LOOP_EN
  // Set once the current request has already followed one END redirect, so a
  // second END (END at the loop target) halts instead of looping forever.
  logic end_seen;
`else
  logic unused_loop_addr;
  assign unused_loop_addr = ^i_loop_addr;
`endif

  // Request FSM, read pointer and registered note outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      o_valid    <= 1'b0;
      o_pitch    <= '0;
      o_duration <= '0;
      o_rest     <= 1'b0;
      o_halted   <= 1'b0;
`ifdef PATTERN_SEQUENCER_LOOP_EN
      end_seen   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state/ptr regardless of statement order.
      // NOTE: o_valid defaults low each cycle; branches only raise it, which
      // makes it a guaranteed single-cycle pulse.
      o_valid <= 1'b0;
      if (i_restart) begin
        // Restart wins over everything, including a same-cycle enable and any
        // fetch in flight (its data is simply never reported).
        ptr      <= i_start_addr;
        o_halted <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_enable) begin
              if (o_halted) begin
                // Halted: answer immediately with a silent zero-length note.
                o_valid    <= 1'b1;
                o_rest     <= 1'b1;
                o_duration <= '0;
              end else begin
                state <= FETCH;
`ifdef PATTERN_SEQUENCER_LOOP_EN
                end_seen <= 1'b0;
`endif
              end
            end
          end
          FETCH: state <= WAIT;
          WAIT: begin
            if (!entry_end) begin
              o_valid    <= 1'b1;
              o_pitch    <= entry_pitch;
              o_duration <= entry_duration;
              o_rest     <= entry_rest;
              ptr        <= ptr + ADDR_WIDTH'(1);
              state      <= IDLE;
`ifdef PATTERN_SEQUENCER_LOOP_EN
            end else if (!end_seen) begin
              end_seen <= 1'b1;
              state    <= DECODE_END;
`endif
            end else begin
              // Terminal END: stop here, pitch left as last played.
              o_halted   <= 1'b1;
              o_valid    <= 1'b1;
              o_rest     <= 1'b1;
              o_duration <= '0;
              state      <= IDLE;
            end
          end
`ifdef PATTERN_SEQUENCER_LOOP_EN
          DECODE_END: begin
            ptr   <= i_loop_addr;
            state <= FETCH;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed scoreboard bench for pattern_sequencer.
// Stimulus pushes the expected note (and the cycle it must appear in) into a
// queue; a monitor pops and compares on every o_valid pulse.
module tb_pattern_sequencer;

  localparam int AW = 6;
  localparam int PW = 6;
  localparam int DW = 8;
  localparam int EW = 2 + PW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          restart;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] loop_addr;
  logic          valid;
  logic [PW-1:0] pitch;
  logic [DW-1:0] duration;
  logic          rest;
  logic          halted;
  logic          busy;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [EW-1:0] rom_data;

  logic [EW-1:0] rom [0:(1<<AW)-1];

  always #5 clk = ~clk;

  pattern_sequencer #(.ADDR_WIDTH(AW), .PITCH_WIDTH(PW), .DURATION_WIDTH(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_restart   (restart),
    .i_start_addr(start_addr),
    .i_loop_addr (loop_addr),
    .o_valid     (valid),
    .o_pitch     (pitch),
    .o_duration  (duration),
    .o_rest      (rest),
    .o_halted    (halted),
    .o_busy      (busy),
    .o_rom_en    (rom_en),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data)
  );

  // Synchronous pattern ROM: data valid the cycle after the read enable.
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] pitch;
    logic [DW-1:0] dur;
    logic          rest;
    logic          halted;
    int unsigned   when;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_valid: got o_valid=1, expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("valid_cycle", cyc, mon_e.when);
        check("pitch", pitch, mon_e.pitch);
        check("duration", duration, mon_e.dur);
        check("rest", rest, mon_e.rest);
        check("halted", halted, mon_e.halted);
      end
    end
  end

  function automatic logic [EW-1:0] ent(input logic e, input logic r,
                                        input logic [PW-1:0] p, input logic [DW-1:0] d);
    return {e, r, p, d};
  endfunction

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL response_timeout: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // One enable strobe with its expected response lat cycles later.
  task automatic request(input logic [PW-1:0] p, input logic [DW-1:0] d,
                         input logic r, input logic h, input int lat);
    exp_t e;
    @(posedge clk); #1;
    e.pitch = p; e.dur = d; e.rest = r; e.halted = h; e.when = cyc + lat;
    sb.push_back(e);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    drain();
  endtask

  task automatic do_restart(input logic [AW-1:0] a);
    @(posedge clk); #1;
    start_addr = a;
    restart    = 1'b1;
    @(posedge clk); #1;
    restart    = 1'b0;
    @(posedge clk);
  endtask

`ifdef PATTERN_SEQUENCER_LOOP_EN
  localparam logic [PW-1:0] HALT_PITCH = 6'd9;
`else
  localparam logic [PW-1:0] HALT_PITCH = 6'd12;
`endif

  initial begin
    exp_t e;
    for (int i = 0; i < (1<<AW); i++) rom[i] = '0;
    rom[0]  = ent(1'b0, 1'b0, 6'd12, 8'd4);
    rom[1]  = ent(1'b0, 1'b0, 6'd20, 8'd16);
    rom[2]  = ent(1'b0, 1'b1, 6'd9,  8'd8);
    rom[3]  = ent(1'b0, 1'b0, 6'd40, 8'd3);
    rom[5]  = ent(1'b1, 1'b0, 6'd0,  8'd0);
    rom[63] = ent(1'b0, 1'b0, 6'd33, 8'd7);
    rom_data   = '0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    restart    = 1'b0;
    start_addr = '0;
    loop_addr  = '0;

    // Reset values.
    #12;
    check("reset_valid", valid, 0);
    check("reset_data", {pitch, duration, rest}, 0);
    check("reset_halted", halted, 0);
    check("reset_busy_rom", {busy, rom_en, rom_addr}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // First note, pointer advance, data hold.
    request(6'd12, 8'd4, 1'b0, 1'b0, 3);
    check("ptr_after_first", rom_addr, 1);
    repeat (3) @(posedge clk);
    check("hold_pitch", pitch, 12);
    check("hold_duration", duration, 4);
    request(6'd20, 8'd16, 1'b0, 1'b0, 3);
    check("ptr_after_second", rom_addr, 2);

    // Pointer wrap 63 -> 0.
    do_restart(6'd63);
    request(6'd33, 8'd7, 1'b0, 1'b0, 3);
    request(6'd12, 8'd4, 1'b0, 1'b0, 3);
    check("ptr_after_wrap", rom_addr, 1);

    // END entry at 5.
    loop_addr = 6'd2;
    do_restart(6'd5);
`ifdef PATTERN_SEQUENCER_LOOP_EN
    request(6'd9, 8'd8, 1'b1, 1'b0, 6);
    check("ptr_after_loop", rom_addr, 3);
`else
    request(6'd12, 8'd0, 1'b1, 1'b1, 3);
    check("halted_on_end", halted, 1);
`endif

    // END at its own loop target -> halt; halted rest at T+1; restart clears.
    loop_addr = 6'd5;
    do_restart(6'd5);
    check("halt_cleared_by_restart", halted, 0);
`ifdef PATTERN_SEQUENCER_LOOP_EN
    request(HALT_PITCH, 8'd0, 1'b1, 1'b1, 6);
`else
    request(HALT_PITCH, 8'd0, 1'b1, 1'b1, 3);
`endif
    check("halted_set", halted, 1);
    request(HALT_PITCH, 8'd0, 1'b1, 1'b1, 1);
    do_restart(6'd0);
    check("halted_clear", halted, 0);

    // Extra enables while busy are ignored.
    @(posedge clk); #1;
    e.pitch = 6'd12; e.dur = 8'd4; e.rest = 1'b0; e.halted = 1'b0; e.when = cyc + 3;
    sb.push_back(e);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    check("ptr_after_busy_enables", rom_addr, 1);

    // Restart during WAIT abandons the fetch.
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    check("in_wait_busy", busy, 1);
    start_addr = 6'd3;
    restart    = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abandon_idle", busy, 0);
    check("abandon_ptr", rom_addr, 3);
    request(6'd40, 8'd3, 1'b0, 1'b0, 3);

    // Restart and enable in the same cycle: restart wins.
    @(posedge clk); #1;
    start_addr = 6'd0;
    restart    = 1'b1;
    enable     = 1'b1;
    @(posedge clk); #1;
    restart    = 1'b0;
    enable     = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("restart_wins_busy", busy, 0);
    check("restart_wins_ptr", rom_addr, 0);
    request(6'd12, 8'd4, 1'b0, 1'b0, 3);

    // Asynchronous reset in FETCH.
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    check("fetch_rom_en", rom_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid_busy", {valid, busy, rom_en}, 0);
    check("areset_data", {pitch, duration, rest, halted}, 0);
    check("areset_rom_addr", rom_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
